// File: rtl/jk_ff_bank.sv
// Bank of WIDTH JK flip-flops with JK / D / T / COUNT operating modes.
// Optional change counter output chg_cnt enabled by defining JK_FF_BANK_CHG_CNT_EN.
module jk_ff_bank #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             changed,
    output logic             tc
`ifdef JK_FF_BANK_CHG_CNT_EN
    ,
    output logic [15:0]      chg_cnt
`endif
);

    localparam int unsigned CNT_W      = 16;
    localparam logic [1:0]  MODE_JK    = 2'b00;
    localparam logic [1:0]  MODE_D     = 2'b01;
    localparam logic [1:0]  MODE_T     = 2'b10;
    localparam logic [1:0]  MODE_COUNT = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] j_eff, k_eff, carry;

    // Every mode is mapped onto per-bit J/K inputs so one JK update equation serves all.
    always_comb begin
        j_eff    = J;
        k_eff    = K;
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            carry[i] = carry[i-1] & q_q[i-1];
        end
        case (mode)
            MODE_JK: begin
                j_eff = J;
                k_eff = K;
            end
            MODE_D: begin
                j_eff = J;
                k_eff = ~J;
            end
            MODE_T: begin
                j_eff = J;
                k_eff = J;
            end
            MODE_COUNT: begin
                j_eff = carry;
                k_eff = carry;
            end
            default: begin
                j_eff = J;
                k_eff = K;
            end
        endcase

        q_d       = q_q;
        changed_d = 1'b0;
        if (en) begin
            q_d       = (j_eff & ~q_q) | (~k_eff & q_q);
            changed_d = (q_d != q_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= RESET_VAL;
            changed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            changed_q <= changed_d;
        end
    end

    assign q       = q_q;
    assign qb      = ~q_q;
    assign changed = changed_q;
    assign tc      = (mode == MODE_COUNT) && (&q_q);

`ifdef JK_FF_BANK_CHG_CNT_EN
    logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;

    // Saturating count of edges on which changed gets set.
    always_comb begin
        chg_cnt_d = chg_cnt_q;
        if (changed_d && (chg_cnt_q != {CNT_W{1'b1}})) begin
            chg_cnt_d = chg_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chg_cnt_q <= '0;
        end else begin
            chg_cnt_q <= chg_cnt_d;
        end
    end

    assign chg_cnt = chg_cnt_q;
`endif

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed self-checking bench for jk_ff_bank (WIDTH=4, RESET_VAL=0).
// Define JK_FF_BANK_CHG_CNT_EN to also exercise the chg_cnt saturation path.
module tb_jk_ff_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] J;
    logic [3:0] K;
    logic [3:0] q;
    logic [3:0] qb;
    logic       changed;
    logic       tc;
`ifdef JK_FF_BANK_CHG_CNT_EN
    logic [15:0] chg_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    jk_ff_bank #(.WIDTH(4), .RESET_VAL(4'h0)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .J       (J),
        .K       (K),
        .q       (q),
        .qb      (qb),
        .changed (changed),
        .tc      (tc)
`ifdef JK_FF_BANK_CHG_CNT_EN
        ,
        .chg_cnt (chg_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 2'b00; J = 4'hF; K = 4'hF;
        tick();
        rst = 1'b0;
        n_tests++;
        if (q !== 4'h0) begin n_fail++; $display("FAIL reset_q got %h exp 0", q); end
        n_tests++;
        if (qb !== 4'hF) begin n_fail++; $display("FAIL reset_qb got %h exp F", qb); end
        n_tests++;
        if (changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed got %b exp 0", changed); end
        n_tests++;
        if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc got %b exp 0", tc); end
    endtask

    task automatic test_jk();
        logic [3:0] vj [6] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'hC, 4'hC};
        logic [3:0] vk [6] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'hA, 4'hA};
        logic [3:0] eq [6] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'hC, 4'h4};
        logic       ec [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        mode = 2'b00; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            J = vj[i]; K = vk[i];
            tick();
            n_tests++;
            if (q !== eq[i]) begin n_fail++; $display("FAIL jk_q[%0d] got %h exp %h", i, q, eq[i]); end
            n_tests++;
            if (changed !== ec[i]) begin n_fail++; $display("FAIL jk_changed[%0d] got %b exp %b", i, changed, ec[i]); end
        end
    endtask

    task automatic test_d();
        logic [3:0] vj [4] = '{4'h9, 4'h9, 4'h6, 4'hF};
        logic [3:0] vk [4] = '{4'hF, 4'h0, 4'h0, 4'h5};
        logic       ec [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        mode = 2'b01; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            J = vj[i]; K = vk[i];
            tick();
            n_tests++;
            if (q !== vj[i]) begin n_fail++; $display("FAIL d_q[%0d] got %h exp %h", i, q, vj[i]); end
            n_tests++;
            if (changed !== ec[i]) begin n_fail++; $display("FAIL d_changed[%0d] got %b exp %b", i, changed, ec[i]); end
        end
        n_tests++;
        if (tc !== 1'b0) begin n_fail++; $display("FAIL d_tc_at_F got %b exp 0", tc); end
    endtask

    task automatic test_toggle();
        logic [3:0] eq [3] = '{4'h5, 4'h0, 4'h0};
        logic       ec [3] = '{1'b1, 1'b1, 1'b0};
        logic       ee [3] = '{1'b1, 1'b1, 1'b0};
        do_reset();
        mode = 2'b10; J = 4'h5; K = 4'hA;
        for (int i = 0; i < 3; i++) begin
            en = ee[i];
            tick();
            n_tests++;
            if (q !== eq[i]) begin n_fail++; $display("FAIL t_q[%0d] got %h exp %h", i, q, eq[i]); end
            n_tests++;
            if (changed !== ec[i]) begin n_fail++; $display("FAIL t_changed[%0d] got %b exp %b", i, changed, ec[i]); end
        end
        en = 1'b1; J = 4'h6;
        tick();
        en = 1'b0; J = 4'hF;
        tick();
        n_tests++;
        if (q !== 4'h6) begin n_fail++; $display("FAIL t_hold_q got %h exp 6", q); end
        n_tests++;
        if (changed !== 1'b0) begin n_fail++; $display("FAIL t_hold_changed got %b exp 0", changed); end
    endtask

    task automatic test_count();
        logic [3:0] exp_q;
        do_reset();
        mode = 2'b11; en = 1'b1; J = 4'h3; K = 4'hC;
        for (int i = 1; i <= 17; i++) begin
            exp_q = 4'(i % 16);
            tick();
            n_tests++;
            if (q !== exp_q) begin n_fail++; $display("FAIL cnt_q[%0d] got %h exp %h", i, q, exp_q); end
            n_tests++;
            if (tc !== (exp_q == 4'hF)) begin n_fail++; $display("FAIL cnt_tc[%0d] got %b exp %b", i, tc, exp_q == 4'hF); end
            n_tests++;
            if (changed !== 1'b1) begin n_fail++; $display("FAIL cnt_changed[%0d] got %b exp 1", i, changed); end
        end
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        mode = 2'b11; en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        n_tests++;
        if (q !== 4'h7) begin n_fail++; $display("FAIL rmc_pre_q got %h exp 7", q); end
        rst = 1'b1;
        tick();
        n_tests++;
        if (q !== 4'h0) begin n_fail++; $display("FAIL rmc_q got %h exp 0", q); end
        n_tests++;
        if (changed !== 1'b0) begin n_fail++; $display("FAIL rmc_changed got %b exp 0", changed); end
        rst = 1'b0;
        tick();
        n_tests++;
        if (q !== 4'h1) begin n_fail++; $display("FAIL rmc_after_q got %h exp 1", q); end
        mode = 2'b01; J = 4'hB; en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (q !== 4'h0) begin n_fail++; $display("FAIL rst_over_en_q got %h exp 0", q); end
    endtask

    task automatic test_mode_switch();
        logic [1:0] vm [4] = '{2'b11, 2'b01, 2'b11, 2'b00};
        logic [3:0] vj [4] = '{4'h0, 4'hE, 4'h0, 4'h3};
        logic [3:0] vk [4] = '{4'h0, 4'h0, 4'h0, 4'hC};
        logic [3:0] eq [4] = '{4'h1, 4'hE, 4'hF, 4'h3};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mode = vm[i]; J = vj[i]; K = vk[i];
            tick();
            n_tests++;
            if (q !== eq[i]) begin n_fail++; $display("FAIL ms_q[%0d] got %h exp %h", i, q, eq[i]); end
        end
        mode = 2'b00; J = 4'hC; K = 4'h0;
        tick();
        n_tests++;
        if (tc !== 1'b0) begin n_fail++; $display("FAIL ms_tc_jk got %b exp 0", tc); end
        mode = 2'b11; en = 1'b0;
        #1;
        n_tests++;
        if (tc !== 1'b1) begin n_fail++; $display("FAIL ms_tc_count got %b exp 1", tc); end
    endtask

`ifdef JK_FF_BANK_CHG_CNT_EN
    task automatic test_chg_cnt();
        do_reset();
        n_tests++;
        if (chg_cnt !== 16'h0000) begin n_fail++; $display("FAIL chg_reset got %h exp 0000", chg_cnt); end
        mode = 2'b10; J = 4'h1; en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (chg_cnt !== 16'd5) begin n_fail++; $display("FAIL chg_count5 got %0d exp 5", chg_cnt); end
        en = 1'b0;
        tick();
        n_tests++;
        if (chg_cnt !== 16'd5) begin n_fail++; $display("FAIL chg_hold got %0d exp 5", chg_cnt); end
        en = 1'b1;
        for (int i = 0; i < 69995; i++) tick();
        n_tests++;
        if (chg_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL chg_sat got %h exp FFFF", chg_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (chg_cnt !== 16'h0000) begin n_fail++; $display("FAIL chg_clear got %h exp 0000", chg_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; J = 4'h0; K = 4'h0;
        test_reset();
        test_jk();
        test_d();
        test_toggle();
        test_count();
        test_reset_mid_count();
        test_mode_switch();
`ifdef JK_FF_BANK_CHG_CNT_EN
        test_chg_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_ff_bank.md
JK_FF_BANK -- requirements
Module: jk_ff_bank

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning number of JK flip-flop bits (legal 1..32).
REQ-002 SHALL provide parameter RESET_VAL, default 0, meaning value loaded into q on reset (WIDTH bits).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port en  input  1  update enable; when 0, all state holds.
REQ-006 SHALL provide port mode  input  2  operating mode: 00 JK, 01 D, 10 T, 11 COUNT.
REQ-007 SHALL provide port J  input  WIDTH  per-bit J / D / T data input.
REQ-008 SHALL provide port K  input  WIDTH  per-bit K input, used in JK mode only.
REQ-009 SHALL provide port q  output  WIDTH  registered flip-flop state.
REQ-010 SHALL provide port qb  output  WIDTH  bitwise inverse of q, combinational.
REQ-011 SHALL provide port changed  output  1  registered flag: q changed on previous edge.
REQ-012 SHALL provide port tc  output  1  terminal count: mode==11 and q all-ones, combinational.

Function
REQ-013 JK mode: per bit, J=0 K=0 hold; J=0 K=1 clear; J=1 K=0 set; J=1 K=1 toggle.
REQ-014 D mode: q <= J on enabled edge; K ignored.
REQ-015 T mode: bit i toggles when J[i]=1, holds when J[i]=0; K ignored.
REQ-016 COUNT mode: q <= q + 1 modulo 2^WIDTH on each enabled edge; J and K ignored; all-ones wraps to 0.
REQ-017 COUNT increment SHALL be realised as synchronous JK toggle chain: bit i toggles iff bits 0..i-1 are all 1 (bit 0 always toggles).
REQ-018 Latency: every q update visible one cycle after the sampling edge; no combinational path from J/K/mode to q.
REQ-019 en=0: q, changed and optional counter hold; changed SHALL be 0 on the edge following an en=0 cycle.
REQ-020 changed SHALL be set to 1 on an edge where the new q differs from the old q, else 0.
REQ-021 Mode change between cycles SHALL take effect on the same edge the new mode is sampled; no pipeline flush or idle cycle.
REQ-022 tc SHALL be 0 in modes 00/01/10 regardless of q.

Reset
REQ-023 rst=1 at rising edge: q <= RESET_VAL, changed <= 0, optional counter <= 0.
REQ-024 rst SHALL take priority over en and mode; reset mid-count discards the pending increment.
REQ-025 First edge after rst deasserts SHALL operate normally from RESET_VAL.

Configuration
REQ-026 Macro JK_FF_BANK_CHG_CNT_EN defined: add output chg_cnt (16 bits) counting edges where changed is set, saturating at 0xFFFF, cleared by rst.
REQ-027 Macro JK_FF_BANK_CHG_CNT_EN undefined: chg_cnt port and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=4, RESET_VAL=0)
REQ-028 rst=1 one edge with J=F K=F mode=00 -> q=0, qb=F, changed=0.
REQ-029 mode=00 en=1, sequence J/K = 0/0, 0/1, 1/0, 1/1 per edge on all bits -> q = 0, 0, F, 0; changed = 0, 0, 1, 1.
REQ-030 mode=11 en=1 for 17 edges from q=0 -> q counts 1..F then 0 then 1; tc=1 only while q=F.
REQ-031 mode=10 J=5 from q=0, two edges, en=0 on third -> q=5, 0, 0; changed=1, 1, 0.
REQ-032 mode=11 q=7, rst=1 with en=1 -> q=0, not 8; changed=0.
REQ-033 JK_FF_BANK_CHG_CNT_EN defined, mode=10 J=1 for 70000 edges -> chg_cnt saturates at 0xFFFF; undefined build elaborates without chg_cnt.
